data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 16 +
 rtl/resp_delay_line.sv | 38 +++
 rtl/data_mem_responder.sv | 99 +++++++++
 tb/tb_data_mem_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, the out-of-range read pattern and the response-stage record
// used by data_mem_responder and its response delay line.
package mem_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    localparam logic [WORD_W-1:0] ERR_PATTERN = 32'hDEADBEEF;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] rdata;
    } resp_t;

endpackage

// File: rtl/resp_delay_line.sv
// Fixed-depth shift register of response records; a record entering on one
// edge leaves DEPTH cycles later. Reset flushes every stage.
module resp_delay_line
    import mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  resp_t in_i,
    output resp_t out_o
);

    resp_t stage_q [DEPTH];
    resp_t stage_d [DEPTH];

    // NOTE: every element of stage_d is assigned on every pass, so no latch is inferred.
    always_comb begin
        stage_d[0] = in_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a req/gnt/rvalid interface with a fixed
// response latency and a cap on granted-but-unanswered requests.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int MEM_WORDS       = 1024,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    input  logic                      data_we_i,
    input  logic [BYTES_PER_WORD-1:0] data_be_i,
    input  logic [31:0]               data_addr_i,
    input  logic [WORD_W-1:0]         data_wdata_i,
    output logic                      data_rvalid_o,
    output logic [WORD_W-1:0]         data_rdata_o,
    output logic                      err_o
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [29:0]      WORDS_LIM = 30'(MEM_WORDS);

    logic [WORD_W-1:0] mem_q [MEM_WORDS];

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [29:0]      word_idx;
    logic [IDX_W-1:0] mem_idx;
    logic             in_range;
    logic             gnt;
    resp_t            resp_in, resp_out;
    logic             unused_addr_lsbs;

    assign word_idx         = data_addr_i[31:2];
    assign mem_idx          = word_idx[IDX_W-1:0];
    assign in_range         = (word_idx < WORDS_LIM);
    assign unused_addr_lsbs = ^data_addr_i[1:0];

    // A response leaving this cycle frees its slot for a same-cycle grant.
    assign gnt = data_req_i & ~rst_i & ((cnt_q < CNT_MAX) | resp_out.valid);

    always_comb begin
        resp_in       = '0;
        resp_in.valid = gnt;
        if (gnt && !data_we_i) begin
            resp_in.rdata = in_range ? mem_q[mem_idx] : ERR_PATTERN;
        end

        cnt_d = cnt_q;
        case ({gnt, resp_out.valid})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        err_d = err_q | (gnt & ~in_range);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // NOTE: the storage array has no reset so its contents survive rst_i and it maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (gnt && data_we_i && in_range) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if (data_be_i[b]) begin
                    mem_q[mem_idx][b*BYTE_W +: BYTE_W] <= data_wdata_i[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    resp_delay_line #(
        .DEPTH (LATENCY)
    ) u_resp_delay_line (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in_i  (resp_in),
        .out_o (resp_out)
    );

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = resp_out.valid;
    assign data_rdata_o  = resp_out.valid ? resp_out.rdata : '0;
    assign err_o         = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset and cap corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_data_mem_responder;

    localparam int MEM_WORDS = 1024;
    localparam int LAT       = 2;
    localparam int MAXO      = 2;
    localparam int N_RAND    = 10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we, gnt, rvalid, err;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
    logic        req2, we2, gnt2, rvalid2, err2;
    logic [3:0]  be2;
    logic [31:0] addr2, wdata2, rdata2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt), .data_we_i(we),
        .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .data_rvalid_o(rvalid),
        .data_rdata_o(rdata), .err_o(err)
    );

    data_mem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(3), .MAX_OUTSTANDING(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req2), .data_gnt_o(gnt2), .data_we_i(we2),
        .data_be_i(be2), .data_addr_i(addr2), .data_wdata_i(wdata2), .data_rvalid_o(rvalid2),
        .data_rdata_o(rdata2), .err_o(err2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        req = r; we = w; be = b; addr = a; wdata = d;
    endtask

    task automatic drive2(input logic r, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d);
        req2 = r; we2 = w; be2 = b; addr2 = a; wdata2 = d;
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_gnt;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [31:0] mask;
    } exp_t;

    vec_t        tbl [25];
    exp_t        q [$];
    logic [31:0] mmem  [MEM_WORDS];
    logic [3:0]  mknown[MEM_WORDS];

    initial begin
        logic [7:0]  g_pat;
        logic [7:0]  r_pat;
        logic        exp_gnt, exp_rv, exp_err, in_rng;
        logic [31:0] a, d, m;
        logic [3:0]  b;
        logic        r, w;
        int          idx, n_gnt, n_rv;
        exp_t        e;

        tbl[0]  = '{1'b1, 1'b1, 4'hF, 32'h10,   32'h11223344, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b0, 4'hF, 32'h10,   32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h11223344, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 4'hF, 32'h20,   32'hAABBCCDD, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[5]  = '{1'b1, 1'b1, 4'h1, 32'h20,   32'h00000055, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 1'b0, 4'hF, 32'h20,   32'h0,        1'b1, 1'b1, 32'h0,        1'b0};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'hAABBCC55, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 4'h0, 32'h20,   32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 1'b0, 4'h3, 32'h22,   32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h0,        1'b0};
        tbl[12] = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'hAABBCC55, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 4'hF, 32'h10,   32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        tbl[14] = '{1'b1, 1'b0, 4'hF, 32'h10,   32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        tbl[15] = '{1'b1, 1'b0, 4'hF, 32'h10,   32'h0,        1'b1, 1'b1, 32'h11223344, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h11223344, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h11223344, 1'b0};
        tbl[18] = '{1'b1, 1'b1, 4'hF, 32'h0,    32'h0BADF00D, 1'b1, 1'b0, 32'h0,        1'b0};
        tbl[19] = '{1'b1, 1'b0, 4'hF, 32'h1000, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        tbl[20] = '{1'b1, 1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0,        1'b1};
        tbl[21] = '{1'b1, 1'b0, 4'hF, 32'h0,    32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b1};
        tbl[22] = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h0,        1'b1};
        tbl[23] = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b1, 32'h0BADF00D, 1'b1};
        tbl[24] = '{1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        1'b0, 1'b0, 32'h0,        1'b1};

        // Reset state, with a request pending that must not be granted.
        rst = 1'b1;
        drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        drive2(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt",    32'(gnt),    32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata",  rdata,       32'h0);
        check("rst_err",    32'(err),    32'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table on the LATENCY=2 / MAX_OUTSTANDING=2 instance.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(tbl[i].req, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata);
            #1;
            check($sformatf("tbl%0d_gnt", i),    32'(gnt),    32'(tbl[i].exp_gnt));
            check($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].exp_rvalid));
            check($sformatf("tbl%0d_rdata", i),  rdata,       tbl[i].exp_rdata);
            check($sformatf("tbl%0d_err", i),    32'(err),    32'(tbl[i].exp_err));
        end

        // Reset just before the first response of two in-flight reads.
        @(negedge clk);
        drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        #1;
        check("midrst_gnt_a", 32'(gnt), 32'h1);
        @(negedge clk);
        #1;
        check("midrst_gnt_b", 32'(gnt), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_rvalid_in_rst", 32'(rvalid), 32'h0);
        check("midrst_gnt_in_rst",    32'(gnt),    32'h0);
        check("midrst_err_cleared",   32'(err),    32'h0);
        @(negedge clk);
        #1;
        check("midrst_rvalid_hold", 32'(rvalid), 32'h0);
        check("midrst_rdata_hold",  rdata,       32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_gnt_a",    32'(gnt),    32'h1);
        check("postrst_rvalid_a", 32'(rvalid), 32'h0);
        @(negedge clk);
        #1;
        check("postrst_gnt_b",    32'(gnt),    32'h1);
        check("postrst_rvalid_b", 32'(rvalid), 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        check("postrst_rvalid_c", 32'(rvalid), 32'h1);
        check("postrst_mem_kept", rdata,       32'h11223344);
        @(negedge clk);
        #1;
        check("postrst_rvalid_d", 32'(rvalid), 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("postrst_quiet%0d", k), 32'(rvalid), 32'h0);
        end

        // LATENCY=3, MAX_OUTSTANDING=1: held request is granted every third cycle.
        g_pat = 8'b0000_1001;
        r_pat = 8'b0100_1000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive2(k < 6, 1'b1, 4'hF, 32'h40, 32'(k));
            #1;
            check($sformatf("cap_gnt%0d", k),    32'(gnt2),    32'(g_pat[k]));
            check($sformatf("cap_rvalid%0d", k), 32'(rvalid2), 32'(r_pat[k]));
        end

        // A request withdrawn while not granted must leave no trace.
        @(negedge clk);
        drive2(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        #1;
        check("drop_gnt_first", 32'(gnt2), 32'h1);
        @(negedge clk);
        #1;
        check("drop_gnt_blocked", 32'(gnt2), 32'h0);
        @(negedge clk);
        drive2(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("drop_rvalid%0d", k), 32'(rvalid2), (k == 1) ? 32'h1 : 32'h0);
            if (k == 1) check("drop_rdata", rdata2, 32'h3);
            @(negedge clk);
        end

        // Randomized traffic against a due-time queue and a byte-tracked memory model.
        for (int i = 0; i < MEM_WORDS; i++) begin
            mknown[i] = 4'h0;
            mmem[i]   = 32'h0;
        end
        exp_err = 1'b0;
        n_gnt   = 0;
        n_rv    = 0;
        for (int cyc = 0; cyc < N_RAND + LAT + 2; cyc++) begin
            @(negedge clk);
            r = (cyc < N_RAND) && ($urandom_range(0, 3) != 0);
            w = 1'($urandom_range(0, 1));
            b = 4'($urandom_range(0, 15));
            d = $urandom;
            if ($urandom_range(0, 15) == 0)
                a = 32'h0000_1000 + ($urandom & 32'h00FF_FFFF);
            else
                a = 32'((64 + $urandom_range(0, 15)) * 4 + $urandom_range(0, 3));
            drive(r, w, b, a, d);
            #1;
            exp_rv  = (q.size() > 0) && (q[0].due == cyc);
            exp_gnt = r && ((q.size() < MAXO) || exp_rv);
            check("rand_gnt",    32'(gnt),    32'(exp_gnt));
            check("rand_rvalid", 32'(rvalid), 32'(exp_rv));
            check("rand_err",    32'(err),    32'(exp_err));
            if (rvalid) n_rv++;
            if (exp_rv) begin
                e = q.pop_front();
                if (e.mask != 32'h0) check("rand_rdata", rdata & e.mask, e.data & e.mask);
            end else begin
                check("rand_rdata_idle", rdata, 32'h0);
            end
            if (exp_gnt) begin
                n_gnt++;
                idx    = int'(a[31:2]);
                in_rng = (a[31:2] < 30'(MEM_WORDS));
                e.due  = cyc + LAT;
                e.data = 32'h0;
                e.mask = 32'hFFFF_FFFF;
                if (!in_rng) begin
                    exp_err = 1'b1;
                    if (!w) e.data = 32'hDEADBEEF;
                end else if (w) begin
                    for (int k = 0; k < 4; k++) begin
                        if (b[k]) begin
                            mmem[idx][k*8 +: 8] = d[k*8 +: 8];
                            mknown[idx][k]      = 1'b1;
                        end
                    end
                end else begin
                    e.data = mmem[idx];
                    m = 32'h0;
                    for (int k = 0; k < 4; k++) if (mknown[idx][k]) m[k*8 +: 8] = 8'hFF;
                    e.mask = m;
                end
                q.push_back(e);
            end
        end
        check("rand_rvalid_count", 32'(n_rv), 32'(n_gnt));
        check("rand_queue_empty",  32'(q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
